// File: rtl/demod_decimator.sv
`default_nettype none
// ============================================================================
// Module   : demod_decimator
// Purpose  : Accumulate-and-dump decimator (block mean of DECIM samples) with
//            valid/ready output and sticky overflow flag.
//            Define DEMOD_DECIM_ROUND_EN for round-half-up; default truncates.
// Revision : 1.0 - initial release
// ============================================================================
module demod_decimator #(
   parameter int DECIM      = 8,
   parameter int LOG2_DECIM = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clk_enable,
   input  logic [31:0]           filter_input,
   input  logic                  sync,
   input  logic                  out_ready,
   input  logic                  ovf_clear,
   output logic                  out_valid,
   output logic [31:0]           decim_output,
   output logic                  overflow,
   output logic [LOG2_DECIM-1:0] phase
);

   localparam int                    ACC_W      = 32 + LOG2_DECIM;
   localparam logic [LOG2_DECIM-1:0] LAST_PHASE = LOG2_DECIM'(DECIM - 1);

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] sample_ext;
   logic signed [ACC_W-1:0] sum;
   logic        [31:0]      mean;
   logic                    dump;
   logic                    unused_bits;

   assign sample_ext = {{LOG2_DECIM{filter_input[31]}}, filter_input};
   // acc never holds more than DECIM-1 samples, so this add cannot wrap
   assign sum        = acc + sample_ext;
   assign dump       = clk_enable && !sync && (phase == LAST_PHASE);

`ifdef DEMOD_DECIM_ROUND_EN
   localparam logic signed [ACC_W:0] ROUND_BIAS = (ACC_W + 1)'(DECIM / 2);
   logic signed [ACC_W:0] rounded;

   assign rounded     = {sum[ACC_W-1], sum} + ROUND_BIAS;
   assign mean        = rounded[LOG2_DECIM +: 32];
   assign unused_bits = ^{rounded[ACC_W], rounded[LOG2_DECIM-1:0]};
`else
   assign mean        = sum[LOG2_DECIM +: 32];
   assign unused_bits = ^sum[LOG2_DECIM-1:0];
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc          <= '0;
         phase        <= '0;
         out_valid    <= 1'b0;
         decim_output <= '0;
         overflow     <= 1'b0;
      end else begin
         if (sync) begin
            acc   <= '0;
            phase <= '0;
         end else if (clk_enable) begin
            if (dump) begin
               acc   <= '0;
               phase <= '0;
            end else begin
               acc   <= sum;
               phase <= phase + LOG2_DECIM'(1);
            end
         end

         if (dump) begin
            decim_output <= mean;
            out_valid    <= 1'b1;
         end else if (out_ready) begin
            out_valid    <= 1'b0;
         end

         // a pending result lost to the new one sets the flag; set beats clear
         if (dump && out_valid && !out_ready)
            overflow <= 1'b1;
         else if (ovf_clear)
            overflow <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: doc/demod_decimator.md
# demod_decimator

Accumulate-and-dump decimator that sits directly downstream of the 8 kHz demodulation lowpass filter. It consumes the filter's 32-bit signed output, one sample per `clk_enable` strobe, and averages each block of `DECIM` consecutive samples. Each block mean is emitted as one 32-bit sample on a valid/ready interface at the reduced rate. A sticky flag reports results lost to backpressure.

## Interface
- `DECIM`, default 8: decimation factor; must be a power of two, 2..256.
- `LOG2_DECIM`, default 3: log2(`DECIM`); must match `DECIM`.
- `clk` input 1: system clock; all state on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `clk_enable` input 1: input sample strobe; connects to the lowpass filter's `ce_out`.
- `filter_input` input 32: signed sample; sampled only when `clk_enable`=1.
- `sync` input 1: synchronous block realign; discards the partial block.
- `out_ready` input 1: consumer accepts `decim_output` this cycle.
- `ovf_clear` input 1: synchronous clear of `overflow`.
- `out_valid` output 1: `decim_output` holds an unconsumed result.
- `decim_output` output 32: signed block mean.
- `overflow` output 1: sticky flag; a result was overwritten before it was consumed.
- `phase` output `LOG2_DECIM`: samples accumulated in the current block.

## Operation
- **Accumulator:** signed, 32+`LOG2_DECIM` bits wide. It cannot overflow for any input sequence.
- **Sample cycle** (`clk_enable`=1, `sync`=0):
  - If `phase` < `DECIM`-1: `acc` ← `acc` + sign-extended `filter_input`; `phase` ← `phase`+1.
  - If `phase` = `DECIM`-1 (dump): `sum` = `acc` + `filter_input`; `decim_output` ← mean(`sum`); `out_valid` ← 1; `acc` ← 0; `phase` ← 0.
- **Mean:** arithmetic right shift of `sum` by `LOG2_DECIM`; rounding per Configuration.
  - The result always fits in 32 bits, so no saturation logic is needed.
  - 8×0x7FFFFFFF → 0x7FFFFFFF; 8×0x80000000 → 0x80000000.
- **Handshake:**
  - The transfer occurs on a cycle where `out_valid`=1 and `out_ready`=1. After it, `out_valid` falls next cycle unless a dump occurs in the same cycle.
  - `decim_output` is stable while `out_valid`=1 and no dump occurs.
- **Dump while `out_valid`=1 and `out_ready`=0:** the new result overwrites the old one, `out_valid` stays 1, and `overflow` ← 1.
- **Dump with `out_ready`=1 in the same cycle:** the old result transfers, the new result loads, `out_valid` stays 1, and `overflow` is unchanged.
- **`sync`=1:** `acc` ← 0, `phase` ← 0; any sample present that cycle is discarded. `sync` has priority over `clk_enable` and never generates a dump. The output register and `out_valid` are unaffected.
- **`overflow`:** set has priority over `ovf_clear` in the same cycle.
- **`clk_enable`=0:** accumulator and phase hold. The handshake continues to operate every clock.

## Timing
- **Reset values** (`reset_n`=0): `acc`=0, `phase`=0, `out_valid`=0, `decim_output`=0, `overflow`=0. Reset takes effect immediately, asynchronously. Release is synchronized externally.
- **Latency:** `out_valid` and `decim_output` update on the same rising edge that captures the `DECIM`-th sample. They are visible the cycle after that sample is presented.
- **Reset mid-block:** the partial block is lost. The first result after release uses `DECIM` fresh samples.
- **Throughput:** one result per `DECIM` enabled samples. Back-to-back `clk_enable` on every clock is supported.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- **`DEMOD_DECIM_ROUND_EN` defined:** round-half-up. mean = (`sum` + 2^(`LOG2_DECIM`-1)) >>> `LOG2_DECIM`, computed at accumulator width + 1.
- **Not defined:** truncation toward −∞. mean = `sum` >>> `LOG2_DECIM`.
- The macro has no other effect on behaviour.

## Test plan
All scenarios use `DECIM`=8.
1. **Steady input:** 8 samples of 1000, `clk_enable` every cycle, `out_ready`=1 → one `out_valid` pulse, `decim_output`=1000, `phase` wraps 7→0.
2. **Rounding:**
   - Samples 0..7 (sum 28) → 4 with `DEMOD_DECIM_ROUND_EN`, 3 without.
   - Sum −4 → 0 with the macro, −1 without.
3. **Full scale:** 8×0x7FFFFFFF → 0x7FFFFFFF; 8×0x80000000 → 0x80000000 (both builds).
4. **Backpressure:** `out_ready`=0 across two blocks (means 10, then 20) → `out_valid` held, `decim_output`=20, `overflow`=1. Then `ovf_clear` pulse → `overflow`=0. Then `out_ready`=1 → `out_valid` drops next cycle.
5. **`sync` and reset mid-block:**
   - 5 samples of 500, `sync`, then 8 samples of −300 → result −300.
   - Assert `reset_n`=0 mid-block → all outputs 0 immediately.
   - After release, 8 samples of 7 → result 7.
6. **Sparse enable:** `clk_enable` every 3rd cycle with random `out_ready`, compared against a reference model over 10,000 samples → bit-exact results. No lost results when `out_ready` is held 1.
